// File: rtl/mor1kx_cfgrs_spr_port_pkg.sv
// Shared constants for the group-0 configuration SPR responder: register indices,
// group-field slicing, FSM state and grant encodings.
package mor1kx_cfgrs_spr_port_pkg;

   localparam int SPR_ADDR_W = 16;
   localparam int SPR_DAT_W  = 32;
   localparam int SPR_IDX_W  = 11;
   localparam int GRP_MSB    = 15;
   localparam int GRP_LSB    = 11;

   localparam logic [SPR_IDX_W-1:0] IDX_VR       = 11'd0;
   localparam logic [SPR_IDX_W-1:0] IDX_UPR      = 11'd1;
   localparam logic [SPR_IDX_W-1:0] IDX_CPUCFGR  = 11'd2;
   localparam logic [SPR_IDX_W-1:0] IDX_DMMUCFGR = 11'd3;
   localparam logic [SPR_IDX_W-1:0] IDX_IMMUCFGR = 11'd4;
   localparam logic [SPR_IDX_W-1:0] IDX_DCCFGR   = 11'd5;
   localparam logic [SPR_IDX_W-1:0] IDX_ICCFGR   = 11'd6;
   localparam logic [SPR_IDX_W-1:0] IDX_DCFGR    = 11'd7;
   localparam logic [SPR_IDX_W-1:0] IDX_PCCFGR   = 11'd8;
   localparam logic [SPR_IDX_W-1:0] IDX_VR2      = 11'd9;
   localparam logic [SPR_IDX_W-1:0] IDX_AVR      = 11'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DU   = 2'd2
   } gnt_e;

   function automatic logic [GRP_MSB-GRP_LSB:0] spr_group(input logic [SPR_ADDR_W-1:0] addr);
      return addr[GRP_MSB:GRP_LSB];
   endfunction

endpackage

// File: rtl/mor1kx_cfgrs_spr_port_if.sv
// SPR request/response bundle for one requester; the responder uses the slave view.
interface mor1kx_cfgrs_spr_port_if;
   import mor1kx_cfgrs_spr_port_pkg::*;

   logic [SPR_ADDR_W-1:0] addr;
   logic                  we;
   logic                  stb;
   logic [SPR_DAT_W-1:0]  dat;
   logic                  ack;

   modport master (output addr, we, stb, input dat, ack);
   modport slave  (input addr, we, stb, output dat, ack);
endinterface

// File: rtl/mor1kx_cfgrs_spr_decode.sv
// Combinational register-index to configuration-word mux; unmapped indices read zero.
module mor1kx_cfgrs_spr_decode
   import mor1kx_cfgrs_spr_port_pkg::*;
(
   input  logic [SPR_IDX_W-1:0] idx_i,
   input  logic [SPR_DAT_W-1:0] cfg_vr_i,
   input  logic [SPR_DAT_W-1:0] cfg_vr2_i,
   input  logic [SPR_DAT_W-1:0] cfg_upr_i,
   input  logic [SPR_DAT_W-1:0] cfg_cpucfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_dmmucfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_immucfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_dccfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_iccfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_dcfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_pccfgr_i,
   input  logic [SPR_DAT_W-1:0] cfg_avr_i,
   output logic [SPR_DAT_W-1:0] word_o
);

   always_comb begin
      word_o = '0;
      case (idx_i)
         IDX_VR:       word_o = cfg_vr_i;
         IDX_UPR:      word_o = cfg_upr_i;
         IDX_CPUCFGR:  word_o = cfg_cpucfgr_i;
         IDX_DMMUCFGR: word_o = cfg_dmmucfgr_i;
         IDX_IMMUCFGR: word_o = cfg_immucfgr_i;
         IDX_DCCFGR:   word_o = cfg_dccfgr_i;
         IDX_ICCFGR:   word_o = cfg_iccfgr_i;
         IDX_DCFGR:    word_o = cfg_dcfgr_i;
         IDX_PCCFGR:   word_o = cfg_pccfgr_i;
         IDX_VR2:      word_o = cfg_vr2_i;
         IDX_AVR:      word_o = cfg_avr_i;
         default:      word_o = '0;
      endcase
   end

endmodule

// File: rtl/mor1kx_cfgrs_spr_port.sv
// Group-0 config SPR responder for CPU and debug unit; ack two edges after select, one ack
// per strobe assertion, losing requester simply holds stb until it is served.
module mor1kx_cfgrs_spr_port
   import mor1kx_cfgrs_spr_port_pkg::*;
#(
   parameter int SPR_GROUP          = 0,
   parameter bit OPTION_DU_PRIORITY = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mor1kx_cfgrs_spr_port_if.slave cpu,
   mor1kx_cfgrs_spr_port_if.slave du,
   input  logic [SPR_DAT_W-1:0]  cfg_vr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_vr2_i,
   input  logic [SPR_DAT_W-1:0]  cfg_upr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_cpucfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_dmmucfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_immucfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_dccfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_iccfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_dcfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_pccfgr_i,
   input  logic [SPR_DAT_W-1:0]  cfg_avr_i,
   input  logic                  wro_clr_i,
   output logic                  wro_err_o,
   output logic [SPR_ADDR_W-1:0] wro_addr_o
);

   localparam logic [GRP_MSB-GRP_LSB:0] GRP = SPR_GROUP[GRP_MSB-GRP_LSB:0];

   state_e                state_q, state_d;
   gnt_e                  gnt_q, gnt_d;
   logic [SPR_ADDR_W-1:0] req_addr_q, req_addr_d;
   logic                  req_we_q, req_we_d;
   logic [SPR_DAT_W-1:0]  rdata_q, rdata_d;
   logic                  cpu_ack_q, cpu_ack_d, du_ack_q, du_ack_d;
   logic [SPR_DAT_W-1:0]  cpu_dat_q, cpu_dat_d, du_dat_q, du_dat_d;
   logic                  wro_err_q, wro_err_d;
   logic [SPR_ADDR_W-1:0] wro_addr_q, wro_addr_d;

   logic                  cpu_sel, du_sel, pick_du, gnt_stb;
   logic [SPR_ADDR_W-1:0] sel_addr;
   logic                  sel_we;
   logic [SPR_DAT_W-1:0]  dec_word;

   assign cpu_sel  = cpu.stb && (spr_group(cpu.addr) == GRP);
   assign du_sel   = du.stb && (spr_group(du.addr) == GRP);
   assign pick_du  = du_sel && (!cpu_sel || OPTION_DU_PRIORITY);
   assign sel_addr = pick_du ? du.addr : cpu.addr;
   assign sel_we   = pick_du ? du.we : cpu.we;
   assign gnt_stb  = (gnt_q == GNT_DU) ? du.stb : cpu.stb;

   mor1kx_cfgrs_spr_decode u_decode (
      .idx_i          (sel_addr[SPR_IDX_W-1:0]),
      .cfg_vr_i       (cfg_vr_i),
      .cfg_vr2_i      (cfg_vr2_i),
      .cfg_upr_i      (cfg_upr_i),
      .cfg_cpucfgr_i  (cfg_cpucfgr_i),
      .cfg_dmmucfgr_i (cfg_dmmucfgr_i),
      .cfg_immucfgr_i (cfg_immucfgr_i),
      .cfg_dccfgr_i   (cfg_dccfgr_i),
      .cfg_iccfgr_i   (cfg_iccfgr_i),
      .cfg_dcfgr_i    (cfg_dcfgr_i),
      .cfg_pccfgr_i   (cfg_pccfgr_i),
      .cfg_avr_i      (cfg_avr_i),
      .word_o         (dec_word)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      req_addr_d = req_addr_q;
      req_we_d   = req_we_q;
      rdata_d    = rdata_q;
      cpu_ack_d  = 1'b0;
      du_ack_d   = 1'b0;
      cpu_dat_d  = cpu_dat_q;
      du_dat_d   = du_dat_q;
      wro_err_d  = wro_clr_i ? 1'b0 : wro_err_q;
      wro_addr_d = wro_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_sel || du_sel) begin
               gnt_d      = pick_du ? GNT_DU : GNT_CPU;
               req_addr_d = sel_addr;
               req_we_d   = sel_we;
               // Config words are captured here, so later changes cannot leak into this read
               rdata_d    = sel_we ? '0 : dec_word;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (gnt_q == GNT_DU) begin
               du_ack_d = 1'b1;
               du_dat_d = rdata_q;
            end else begin
               cpu_ack_d = 1'b1;
               cpu_dat_d = rdata_q;
            end
            // A same-cycle clear loses to the set and re-arms capture of this address
            if (req_we_q && (!wro_err_q || wro_clr_i)) begin
               wro_err_d  = 1'b1;
               wro_addr_d = req_addr_q;
            end
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!gnt_stb) begin
               gnt_d   = GNT_NONE;
               state_d = ST_IDLE;
            end
         end
         default: begin
            gnt_d   = GNT_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= GNT_NONE;
         req_addr_q <= '0;
         req_we_q   <= 1'b0;
         rdata_q    <= '0;
         cpu_ack_q  <= 1'b0;
         du_ack_q   <= 1'b0;
         cpu_dat_q  <= '0;
         du_dat_q   <= '0;
         wro_err_q  <= 1'b0;
         wro_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         req_addr_q <= req_addr_d;
         req_we_q   <= req_we_d;
         rdata_q    <= rdata_d;
         cpu_ack_q  <= cpu_ack_d;
         du_ack_q   <= du_ack_d;
         cpu_dat_q  <= cpu_dat_d;
         du_dat_q   <= du_dat_d;
         wro_err_q  <= wro_err_d;
         wro_addr_q <= wro_addr_d;
      end
   end

   assign cpu.ack    = cpu_ack_q;
   assign cpu.dat    = cpu_dat_q;
   assign du.ack     = du_ack_q;
   assign du.dat     = du_dat_q;
   assign wro_err_o  = wro_err_q;
   assign wro_addr_o = wro_addr_q;

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_port.sv
// Bench for the group-0 config SPR responder: vector table, hand sequences, random reads/writes.
module tb_mor1kx_cfgrs_spr_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wro_clr;
   logic        wro_err;
   logic [15:0] wro_addr;
   logic [31:0] cfg_w [11];

   int n_tests = 0;
   int n_fail  = 0;

   mor1kx_cfgrs_spr_port_if cpu_if ();
   mor1kx_cfgrs_spr_port_if du_if ();

   mor1kx_cfgrs_spr_port #(.SPR_GROUP(0), .OPTION_DU_PRIORITY(1'b1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu            (cpu_if),
      .du             (du_if),
      .cfg_vr_i       (cfg_w[0]),
      .cfg_upr_i      (cfg_w[1]),
      .cfg_cpucfgr_i  (cfg_w[2]),
      .cfg_dmmucfgr_i (cfg_w[3]),
      .cfg_immucfgr_i (cfg_w[4]),
      .cfg_dccfgr_i   (cfg_w[5]),
      .cfg_iccfgr_i   (cfg_w[6]),
      .cfg_dcfgr_i    (cfg_w[7]),
      .cfg_pccfgr_i   (cfg_w[8]),
      .cfg_vr2_i      (cfg_w[9]),
      .cfg_avr_i      (cfg_w[10]),
      .wro_clr_i      (wro_clr),
      .wro_err_o      (wro_err),
      .wro_addr_o     (wro_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_du;
      logic [15:0] addr;
      bit          we;
      bit          exp_ack;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vt [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // One complete strobe: raise, wait (bounded) for ack, check ack width, drop, let FSM settle.
   task automatic txn(input bit is_du, input logic [15:0] addr, input bit we, input int max_wait,
                      output bit acked, output logic [31:0] dat, output int lat, output bit other_ack);
      acked = 1'b0; dat = '0; lat = 0; other_ack = 1'b0;
      if (is_du) begin du_if.addr = addr; du_if.we = we; du_if.stb = 1'b1; end
      else       begin cpu_if.addr = addr; cpu_if.we = we; cpu_if.stb = 1'b1; end
      for (int c = 1; c <= max_wait && !acked; c++) begin
         tick();
         if (is_du ? cpu_if.ack : du_if.ack) other_ack = 1'b1;
         if (is_du ? du_if.ack : cpu_if.ack) begin
            acked = 1'b1;
            lat   = c;
            dat   = is_du ? du_if.dat : cpu_if.dat;
         end
      end
      if (is_du) du_if.stb = 1'b0; else cpu_if.stb = 1'b0;
      tick();
      if (acked) chk("ack_width", {31'd0, is_du ? du_if.ack : cpu_if.ack}, 32'd0);
      if (is_du ? cpu_if.ack : du_if.ack) other_ack = 1'b1;
      tick();
   endtask

   bit          acked, other;
   logic [31:0] dat;
   int          lat;
   bit          model_err;
   logic [15:0] model_waddr;

   initial begin
      rst_n = 1'b0; wro_clr = 1'b0;
      cpu_if.addr = '0; cpu_if.we = 1'b0; cpu_if.stb = 1'b0;
      du_if.addr  = '0; du_if.we  = 1'b0; du_if.stb  = 1'b0;
      for (int i = 0; i < 11; i++) cfg_w[i] = 32'hA5A5_0000 + i;
      cfg_w[1] = 32'h0000_0619;

      vt[0] = '{0, 16'h0001, 0, 1, 32'h0000_0619};
      vt[1] = '{1, 16'h0009, 0, 1, 32'hA5A5_0009};
      vt[2] = '{0, 16'h000A, 0, 1, 32'hA5A5_000A};
      vt[3] = '{1, 16'h0003, 0, 1, 32'hA5A5_0003};
      vt[4] = '{0, 16'h0011, 0, 1, 32'h0000_0000};
      vt[5] = '{0, 16'h0800, 0, 0, 32'h0000_0000};
      vt[6] = '{1, 16'h07FF, 0, 1, 32'h0000_0000};
      vt[7] = '{1, 16'hF805, 0, 0, 32'h0000_0000};

      tick(); tick();
      chk("rst_cpu_ack", {31'd0, cpu_if.ack}, 32'd0);
      chk("rst_du_ack",  {31'd0, du_if.ack}, 32'd0);
      chk("rst_cpu_dat", cpu_if.dat, 32'd0);
      chk("rst_du_dat",  du_if.dat, 32'd0);
      chk("rst_wro_err", {31'd0, wro_err}, 32'd0);
      chk("rst_wro_addr", {16'd0, wro_addr}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Table of single-requester reads
      for (int i = 0; i < 8; i++) begin
         txn(vt[i].is_du, vt[i].addr, vt[i].we, 10, acked, dat, lat, other);
         chk($sformatf("vec%0d_ack", i), {31'd0, acked}, {31'd0, vt[i].exp_ack});
         chk($sformatf("vec%0d_other", i), {31'd0, other}, 32'd0);
         if (vt[i].exp_ack) begin
            chk($sformatf("vec%0d_lat", i), lat, 32'd2);
            chk($sformatf("vec%0d_dat", i), dat, vt[i].exp_dat);
         end
      end

      // Simultaneous requests: debug unit first, CPU after DU releases
      cpu_if.addr = 16'h000A; cpu_if.we = 1'b0;
      du_if.addr  = 16'h0000; du_if.we  = 1'b0;
      cpu_if.stb = 1'b1; du_if.stb = 1'b1;
      tick();
      chk("sim_t1_acks", {30'd0, cpu_if.ack, du_if.ack}, 32'd0);
      tick();
      chk("sim_t2_acks", {30'd0, cpu_if.ack, du_if.ack}, 32'd1);
      chk("sim_du_dat", du_if.dat, cfg_w[0]);
      du_if.stb = 1'b0;
      acked = 1'b0; lat = 0; other = 1'b0;
      for (int c = 1; c <= 8 && !acked; c++) begin
         tick();
         if (du_if.ack) other = 1'b1;
         if (cpu_if.ack) begin acked = 1'b1; lat = c; dat = cpu_if.dat; end
      end
      chk("sim_cpu_ack", {31'd0, acked}, 32'd1);
      chk("sim_cpu_lat", lat, 32'd3);
      chk("sim_cpu_dat", dat, cfg_w[10]);
      chk("sim_du_extra", {31'd0, other}, 32'd0);
      tick();
      chk("sim_cpu_width", {31'd0, cpu_if.ack}, 32'd0);
      cpu_if.stb = 1'b0;
      tick(); tick();

      // Writes and the sticky read-only-write flag
      txn(0, 16'h0002, 1, 10, acked, dat, lat, other);
      chk("wr1_ack", {31'd0, acked}, 32'd1);
      chk("wr1_dat", dat, 32'd0);
      chk("wr1_err", {31'd0, wro_err}, 32'd1);
      chk("wr1_addr", {16'd0, wro_addr}, 32'h0002);
      txn(0, 16'h0005, 1, 10, acked, dat, lat, other);
      chk("wr2_ack", {31'd0, acked}, 32'd1);
      chk("wr2_addr", {16'd0, wro_addr}, 32'h0002);
      wro_clr = 1'b1; tick(); wro_clr = 1'b0;
      chk("clr_err", {31'd0, wro_err}, 32'd0);
      txn(1, 16'h0003, 1, 10, acked, dat, lat, other);
      chk("wr3_addr", {16'd0, wro_addr}, 32'h0003);
      cpu_if.addr = 16'h0007; cpu_if.we = 1'b1; cpu_if.stb = 1'b1;
      tick();
      wro_clr = 1'b1;
      tick();
      wro_clr = 1'b0;
      chk("wrclr_ack", {31'd0, cpu_if.ack}, 32'd1);
      chk("wrclr_err", {31'd0, wro_err}, 32'd1);
      chk("wrclr_addr", {16'd0, wro_addr}, 32'h0007);
      cpu_if.stb = 1'b0; cpu_if.we = 1'b0;
      tick(); tick();

      // Strobe held after ack: no second ack until it is re-asserted
      cpu_if.addr = 16'h0001; cpu_if.we = 1'b0; cpu_if.stb = 1'b1;
      tick(); tick();
      chk("hold_first_ack", {31'd0, cpu_if.ack}, 32'd1);
      other = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (cpu_if.ack) other = 1'b1;
      end
      chk("hold_no_reack", {31'd0, other}, 32'd0);
      cpu_if.stb = 1'b0;
      tick();
      txn(0, 16'h0001, 0, 10, acked, dat, lat, other);
      chk("hold_reack", {31'd0, acked}, 32'd1);
      chk("hold_reack_lat", lat, 32'd2);

      // Reset during the RESP cycle of a debug read
      txn(0, 16'h0004, 1, 10, acked, dat, lat, other);
      chk("prerst_err", {31'd0, wro_err}, 32'd1);
      du_if.addr = 16'h0000; du_if.we = 1'b0; du_if.stb = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_du_ack", {31'd0, du_if.ack}, 32'd0);
      chk("midrst_err", {31'd0, wro_err}, 32'd0);
      rst_n = 1'b1;
      acked = 1'b0; lat = 0;
      for (int c = 1; c <= 8 && !acked; c++) begin
         tick();
         if (du_if.ack) begin acked = 1'b1; lat = c; dat = du_if.dat; end
      end
      chk("postrst_ack", {31'd0, acked}, 32'd1);
      chk("postrst_lat", lat, 32'd2);
      chk("postrst_dat", dat, cfg_w[0]);
      du_if.stb = 1'b0;
      tick(); tick();

      // Random traffic against a register-map model
      model_err = 1'b0; model_waddr = '0;
      for (int n = 0; n < 60; n++) begin
         bit          r_du, r_we;
         logic [4:0]  r_grp;
         int          r_idx;
         logic [15:0] r_addr;
         logic [31:0] exp_dat;
         for (int i = 0; i < 11; i++) cfg_w[i] = $urandom;
         r_du  = 1'($urandom_range(0, 1));
         r_grp = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'd0;
         r_idx = $urandom_range(0, 15);
         r_we  = ($urandom_range(0, 3) == 0);
         r_addr = {r_grp, 11'(r_idx)};
         txn(r_du, r_addr, r_we, 10, acked, dat, lat, other);
         chk($sformatf("rnd%0d_other", n), {31'd0, other}, 32'd0);
         if (r_grp == 5'd0) begin
            exp_dat = (r_we || r_idx > 10) ? 32'd0 : cfg_w[r_idx];
            if (r_we && !model_err) begin
               model_err   = 1'b1;
               model_waddr = r_addr;
            end
            chk($sformatf("rnd%0d_ack", n), {31'd0, acked}, 32'd1);
            chk($sformatf("rnd%0d_lat", n), lat, 32'd2);
            chk($sformatf("rnd%0d_dat", n), dat, exp_dat);
         end else begin
            chk($sformatf("rnd%0d_noack", n), {31'd0, acked}, 32'd0);
         end
         chk($sformatf("rnd%0d_err", n), {31'd0, wro_err}, {31'd0, model_err});
         chk($sformatf("rnd%0d_waddr", n), {16'd0, wro_addr}, {16'd0, model_waddr});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
